pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline controller for the five-stage core. It owns the single shared memory port, arbitrating it between instruction fetch (IF) and the load/store stage (MEM). It merges memory waits and the ID load-use request into the global `stall[5:0]` vector consumed by the PC register and every inter-stage register (IF_ID, ID_EX, ...). It also drops fetches made stale by a taken branch.

## Interface
- `ADDR_W`, default 32: memory address width.
- `DATA_W`, default 32: memory data width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `if_req` in 1: IF wants an instruction.
- `if_addr` in ADDR_W: fetch PC.
- `if_inst` out DATA_W: fetched instruction.
- `if_valid` out 1: one-cycle pulse when `if_inst` is valid.
- `mem_req` in 1: MEM stage has a load/store.
- `mem_we` in 1: 1 = store.
- `mem_addr` in ADDR_W: load/store address.
- `mem_wdata` in DATA_W: store data.
- `mem_rdata` out DATA_W: load result.
- `mem_done` out 1: one-cycle pulse when the load/store completes.
- `id_stallreq` in 1: load-use hazard from ID.
- `ex_b_flag` in 1: taken branch/jump resolved in EX.
- `id_b_flag` in 1: taken branch/jump resolved in ID.
- `port_req` out 1: memory request, held until ack.
- `port_we` out 1: memory write enable.
- `port_addr` out ADDR_W: memory address.
- `port_wdata` out DATA_W: memory write data.
- `port_rdata` in DATA_W: memory read data, valid with `port_ack`.
- `port_ack` in 1: one-cycle completion pulse.
- `stall` out 6: hold bits for the pipeline. Bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.

## Operation
- FSM states: IDLE, IF_BUSY, MEM_BUSY.
- **IDLE:**
  - If `mem_req`, latch `mem_we/mem_addr/mem_wdata` into the port registers and go to MEM_BUSY.
  - Else if `if_req`, latch `if_addr` with `port_we`=0 and go to IF_BUSY.
  - MEM always wins: it is the older instruction.
- **IF_BUSY / MEM_BUSY:**
  - `port_req`=1 and the port registers are held stable.
  - On `port_ack`, capture `port_rdata` into `if_inst` or `mem_rdata`, pulse `if_valid` or `mem_done` the next cycle, and return to IDLE.
- **Back-to-back:** IDLE needs no extra cycle. Arbitration and latching happen on the edge that leaves IDLE.
- **Kill flag:**
  - Set when `ex_b_flag|id_b_flag` is high while in IF_BUSY, or in IDLE when the same edge enters IF_BUSY.
  - On the following IF `port_ack`, `if_valid` is suppressed and `kill` is cleared.
  - An in-flight transaction is never aborted on the port.
- **Stall vector:** combinational OR of three contributions.
  - MEM wait: `mem_req` && !`mem_done` → 6'b011111.
  - `id_stallreq` → 6'b000111.
  - IF wait: `if_req` && !`if_valid` → 6'b000011.
  - The OR guarantees monotonicity: `stall[i]` implies `stall[j]` for all j<i.
  - `stall[5]` is always 0.
- A store completes like a load. `mem_rdata` is undefined after a store but still gets registered.

## Timing
- **Reset values:** state IDLE, `port_req`=0, `port_we`=0, `port_addr`=0, `port_wdata`=0, `if_inst`=0, `if_valid`=0, `mem_rdata`=0, `mem_done`=0, `kill`=0.
- **Fetch latency:** `if_req` seen at edge N, `port_req` high from N. With `port_ack` at cycle N+k (k≥1), `if_valid` is high in cycle N+k+1.
- **Same-cycle `mem_req` and `if_req` in IDLE:** MEM is served first. IF is served on the edge after `mem_done` at the earliest.
- **`port_ack` in IDLE:** ignored; no output pulses.
- **Branch flag together with `port_ack`:** the kill applies to that ack (it is suppressed).
- **`rst` mid-transaction:** next cycle is IDLE with `port_req`=0. A late `port_ack` is ignored.
- `if_valid` and `mem_done` are never high together.

## Structure
- `Defines.vh` holds:
  - stall bit indices `STALL_PC..STALL_WB`;
  - state encodings `ST_IDLE/ST_IF/ST_MEM`;
  - `ZeroWord`.
- One sub-module, `port_arb_fsm`, holds the state register, port registers, capture registers and kill flag.
- `pipe_ctrl` keeps the combinational stall merge and instantiates `port_arb_fsm`.

## Test plan
- **Fetch with k=3:** `if_req`, `if_addr`=0x100, `port_rdata`=0x00500093. Expect `port_addr`=0x100 held for 3 cycles, one `if_valid` pulse with `if_inst`=0x00500093, and `stall`=6'b000011 until then.
- **Simultaneous requests:** `mem_req` load @0x2000 and `if_req` @0x104 together. Expect MEM first, `stall`=6'b011111 until `mem_done`, then the fetch of 0x104.
- **Store:** `mem_we`=1, addr 0x3000, data 0xDEADBEEF. Expect `port_we`=1 with that data; `mem_done` pulses; no `if_valid`.
- **Branch kill:** `ex_b_flag` pulsed in the 2nd cycle of IF_BUSY. Expect no `if_valid` on that ack; the next fetch with a new address gives a normal `if_valid`.
- **ID hazard plus fetch:** `id_stallreq` with no memory activity → `stall`=6'b000111. Add a pending `mem_req` → 6'b011111. Check monotonicity of every `stall` value over a 10k-cycle random run.
- **Reset mid-transaction:** `rst` in MEM_BUSY. Expect all outputs at reset values next cycle; a `port_ack` 2 cycles later gives no `mem_done`.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall bit positions, stall
// contribution masks and the memory-port arbiter state encoding.
package pipe_ctrl_pkg;

    localparam int STALL_W  = 6;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Each mask holds every stage at or before the requester, which keeps the merged vector monotonic.
    localparam logic [STALL_W-1:0] STALL_MASK_MEM = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_MASK_ID  = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_MASK_IF  = 6'b000011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IF   = 2'd1,
        ST_MEM  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pipe_ctrl_port_arb_fsm.sv
// Arbiter for the single shared memory port: MEM beats IF, requests are
// latched into port registers and held until the one-cycle ack.
module port_arb_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_mem_req,
    input  logic              i_mem_we,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    input  logic              i_b_flag,
    input  logic [DATA_W-1:0] i_port_rdata,
    input  logic              i_port_ack,
    output logic              o_port_req,
    output logic              o_port_we,
    output logic [ADDR_W-1:0] o_port_addr,
    output logic [DATA_W-1:0] o_port_wdata,
    output logic [DATA_W-1:0] o_if_inst,
    output logic              o_if_valid,
    output logic [DATA_W-1:0] o_mem_rdata,
    output logic              o_mem_done,
    output arb_state_t        o_state,
    output logic              o_kill
);

    arb_state_t        r_state;
    logic              r_port_req;
    logic              r_port_we;
    logic [ADDR_W-1:0] r_port_addr;
    logic [DATA_W-1:0] r_port_wdata;
    logic [DATA_W-1:0] r_if_inst;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_mem_done;
    logic              r_kill;

    // A requester whose completion pulse is showing this cycle is being
    // retired by the pipeline on this edge, so it must not be re-issued.
    logic w_mem_go;
    logic w_if_go;
    assign w_mem_go = i_mem_req && !r_mem_done;
    assign w_if_go  = i_if_req && !r_if_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_port_req   <= 1'b0;
            r_port_we    <= 1'b0;
            r_port_addr  <= '0;
            r_port_wdata <= '0;
            r_if_inst    <= '0;
            r_if_valid   <= 1'b0;
            r_mem_rdata  <= '0;
            r_mem_done   <= 1'b0;
            r_kill       <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_go) begin
                        r_port_req   <= 1'b1;
                        r_port_we    <= i_mem_we;
                        r_port_addr  <= i_mem_addr;
                        r_port_wdata <= i_mem_wdata;
                        r_state      <= ST_MEM;
                    end else if (w_if_go) begin
                        r_port_req  <= 1'b1;
                        r_port_we   <= 1'b0;
                        r_port_addr <= i_if_addr;
                        r_kill      <= i_b_flag;
                        r_state     <= ST_IF;
                    end
                end
                ST_IF: begin
                    if (i_port_ack) begin
                        // A redirect arriving with the ack still squashes it.
                        r_if_inst  <= i_port_rdata;
                        r_if_valid <= !(r_kill || i_b_flag);
                        r_kill     <= 1'b0;
                        r_port_req <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (i_b_flag) begin
                        r_kill <= 1'b1;
                    end
                end
                ST_MEM: begin
                    if (i_port_ack) begin
                        r_mem_rdata <= i_port_rdata;
                        r_mem_done  <= 1'b1;
                        r_port_req  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_port_req <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_port_req   = r_port_req;
    assign o_port_we    = r_port_we;
    assign o_port_addr  = r_port_addr;
    assign o_port_wdata = r_port_wdata;
    assign o_if_inst    = r_if_inst;
    assign o_if_valid   = r_if_valid;
    assign o_mem_rdata  = r_mem_rdata;
    assign o_mem_done   = r_mem_done;
    assign o_state      = r_state;
    assign o_kill       = r_kill;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller top: memory-port arbitration plus the merged,
// monotonic stall vector for the PC and inter-stage registers.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_if_req,
    input  logic [ADDR_W-1:0]  i_if_addr,
    output logic [DATA_W-1:0]  o_if_inst,
    output logic               o_if_valid,
    input  logic               i_mem_req,
    input  logic               i_mem_we,
    input  logic [ADDR_W-1:0]  i_mem_addr,
    input  logic [DATA_W-1:0]  i_mem_wdata,
    output logic [DATA_W-1:0]  o_mem_rdata,
    output logic               o_mem_done,
    input  logic               i_id_stallreq,
    input  logic               i_ex_b_flag,
    input  logic               i_id_b_flag,
    output logic               o_port_req,
    output logic               o_port_we,
    output logic [ADDR_W-1:0]  o_port_addr,
    output logic [DATA_W-1:0]  o_port_wdata,
    input  logic [DATA_W-1:0]  i_port_rdata,
    input  logic               i_port_ack,
    output logic [STALL_W-1:0] o_stall
);

    logic              w_if_valid;
    logic              w_mem_done;
    arb_state_t        w_fsm_state;
    logic              w_fsm_kill;
    logic [STALL_W-1:0] w_stall;

    port_arb_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .i_mem_req    (i_mem_req),
        .i_mem_we     (i_mem_we),
        .i_mem_addr   (i_mem_addr),
        .i_mem_wdata  (i_mem_wdata),
        .i_b_flag     (i_ex_b_flag | i_id_b_flag),
        .i_port_rdata (i_port_rdata),
        .i_port_ack   (i_port_ack),
        .o_port_req   (o_port_req),
        .o_port_we    (o_port_we),
        .o_port_addr  (o_port_addr),
        .o_port_wdata (o_port_wdata),
        .o_if_inst    (o_if_inst),
        .o_if_valid   (w_if_valid),
        .o_mem_rdata  (o_mem_rdata),
        .o_mem_done   (w_mem_done),
        .o_state      (w_fsm_state),
        .o_kill       (w_fsm_kill)
    );

    always_comb begin
        w_stall = '0;
        if (i_mem_req && !w_mem_done) w_stall = w_stall | STALL_MASK_MEM;
        if (i_id_stallreq)            w_stall = w_stall | STALL_MASK_ID;
        if (i_if_req && !w_if_valid)  w_stall = w_stall | STALL_MASK_IF;
    end

    assign o_stall    = w_stall;
    assign o_if_valid = w_if_valid;
    assign o_mem_done = w_mem_done;

    // Kill only lives while a fetch is outstanding.
    a_state_legal: assert property (@(posedge clk) disable iff (rst)
        w_fsm_state inside {ST_IDLE, ST_IF, ST_MEM});
    a_kill_in_if: assert property (@(posedge clk) disable iff (rst)
        w_fsm_kill |-> (w_fsm_state == ST_IF));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one task per scenario, inline checks,
// plus a bounded random run for stall monotonicity and port stability.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        id_stallreq = 1'b0;
  logic        ex_b_flag = 1'b0;
  logic        id_b_flag = 1'b0;
  logic        port_req;
  logic        port_we;
  logic [31:0] port_addr;
  logic [31:0] port_wdata;
  logic [31:0] port_rdata = '0;
  logic        port_ack = 1'b0;
  logic [5:0]  stall;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_if_req     (if_req),
    .i_if_addr    (if_addr),
    .o_if_inst    (if_inst),
    .o_if_valid   (if_valid),
    .i_mem_req    (mem_req),
    .i_mem_we     (mem_we),
    .i_mem_addr   (mem_addr),
    .i_mem_wdata  (mem_wdata),
    .o_mem_rdata  (mem_rdata),
    .o_mem_done   (mem_done),
    .i_id_stallreq(id_stallreq),
    .i_ex_b_flag  (ex_b_flag),
    .i_id_b_flag  (id_b_flag),
    .o_port_req   (port_req),
    .o_port_we    (port_we),
    .o_port_addr  (port_addr),
    .o_port_wdata (port_wdata),
    .i_port_rdata (port_rdata),
    .i_port_ack   (port_ack),
    .o_stall      (stall)
  );

  // Clock/reset block: inputs change and outputs are sampled on negedge.
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dut.w_fsm_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.w_fsm_state, ST_IDLE); end
    checks++; if (port_req !== 1'b0) begin errors++; $display("FAIL reset_port_req: got %b want 0", port_req); end
    checks++; if (port_addr !== 32'h0 || port_wdata !== 32'h0 || port_we !== 1'b0) begin errors++; $display("FAIL reset_port_regs: addr %h wdata %h we %b want 0", port_addr, port_wdata, port_we); end
    checks++; if (if_inst !== 32'h0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_capture: inst %h rdata %h want 0", if_inst, mem_rdata); end
    checks++; if (if_valid !== 1'b0 || mem_done !== 1'b0) begin errors++; $display("FAIL reset_pulses: if_valid %b mem_done %b want 0", if_valid, mem_done); end
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL reset_stall: got %b want 000000", stall); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch_k3();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL fetch_stall_pre: got %b want 000011", stall); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (port_req !== 1'b1 || port_addr !== 32'h100 || port_we !== 1'b0) begin errors++; $display("FAIL fetch_port_c%0d: req %b addr %h we %b want 1 100 0", i, port_req, port_addr, port_we); end
      checks++; if (if_valid !== 1'b0 || stall !== 6'b000011) begin errors++; $display("FAIL fetch_wait_c%0d: if_valid %b stall %b want 0 000011", i, if_valid, stall); end
      if (i == 2) begin port_ack = 1'b1; port_rdata = 32'h0050_0093; end
    end
    @(negedge clk);
    port_ack = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_inst !== 32'h0050_0093) begin errors++; $display("FAIL fetch_valid: if_valid %b inst %h want 1 00500093", if_valid, if_inst); end
    checks++; if (stall !== 6'b000000 || port_req !== 1'b0) begin errors++; $display("FAIL fetch_release: stall %b req %b want 000000 0", stall, port_req); end
    if_req = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || port_req !== 1'b0) begin errors++; $display("FAIL fetch_one_pulse: if_valid %b req %b want 0 0", if_valid, port_req); end
  endtask

  task automatic test_simultaneous();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_wdata = 32'h0;
    if_req = 1'b1; if_addr = 32'h104;
    #1;
    checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL simul_stall_pre: got %b want 011111", stall); end
    @(negedge clk);
    checks++; if (port_req !== 1'b1 || port_addr !== 32'h2000 || port_we !== 1'b0) begin errors++; $display("FAIL simul_mem_first: req %b addr %h we %b want 1 2000 0", port_req, port_addr, port_we); end
    checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL simul_stall_busy: got %b want 011111", stall); end
    port_ack = 1'b1; port_rdata = 32'h1122_3344;
    @(negedge clk);
    port_ack = 1'b0;
    checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'h1122_3344 || if_valid !== 1'b0) begin errors++; $display("FAIL simul_mem_done: done %b rdata %h if_valid %b want 1 11223344 0", mem_done, mem_rdata, if_valid); end
    checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL simul_stall_after_mem: got %b want 000011", stall); end
    mem_req = 1'b0;
    @(negedge clk);
    checks++; if (port_req !== 1'b1 || port_addr !== 32'h104 || port_we !== 1'b0 || mem_done !== 1'b0) begin errors++; $display("FAIL simul_if_next: req %b addr %h we %b done %b want 1 104 0 0", port_req, port_addr, port_we, mem_done); end
    port_ack = 1'b1; port_rdata = 32'h0000_AABB;
    @(negedge clk);
    port_ack = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_AABB) begin errors++; $display("FAIL simul_if_valid: if_valid %b inst %h want 1 0000aabb", if_valid, if_inst); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h3000; mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (port_req !== 1'b1 || port_we !== 1'b1 || port_addr !== 32'h3000 || port_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_port: req %b we %b addr %h wdata %h want 1 1 3000 deadbeef", port_req, port_we, port_addr, port_wdata); end
    port_ack = 1'b1; port_rdata = 32'h0;
    @(negedge clk);
    port_ack = 1'b0;
    checks++; if (mem_done !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL store_done: done %b if_valid %b want 1 0", mem_done, if_valid); end
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    checks++; if (mem_done !== 1'b0 || port_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL store_idle: done %b req %b if_valid %b want 0 0 0", mem_done, port_req, if_valid); end
  endtask

  task automatic test_branch_kill();
    if_req = 1'b1; if_addr = 32'h200;
    @(negedge clk);
    checks++; if (port_req !== 1'b1 || port_addr !== 32'h200) begin errors++; $display("FAIL kill_issue: req %b addr %h want 1 200", port_req, port_addr); end
    @(negedge clk);
    ex_b_flag = 1'b1;
    @(negedge clk);
    ex_b_flag = 1'b0; if_addr = 32'h300;
    checks++; if (port_addr !== 32'h200 || port_req !== 1'b1) begin errors++; $display("FAIL kill_port_held: addr %h req %b want 200 1", port_addr, port_req); end
    port_ack = 1'b1; port_rdata = 32'h0000_0123;
    @(negedge clk);
    port_ack = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL kill_suppress: if_valid %b want 0", if_valid); end
    checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL kill_stall: got %b want 000011", stall); end
    @(negedge clk);
    checks++; if (port_req !== 1'b1 || port_addr !== 32'h300) begin errors++; $display("FAIL kill_refetch: req %b addr %h want 1 300", port_req, port_addr); end
    port_ack = 1'b1; port_rdata = 32'h0000_0456;
    @(negedge clk);
    port_ack = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_0456) begin errors++; $display("FAIL kill_next_valid: if_valid %b inst %h want 1 00000456", if_valid, if_inst); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_kill_with_ack();
    if_req = 1'b1; if_addr = 32'h400;
    @(negedge clk);
    port_ack = 1'b1; port_rdata = 32'h0000_0789; id_b_flag = 1'b1;
    @(negedge clk);
    port_ack = 1'b0; id_b_flag = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL ack_kill: if_valid %b want 0", if_valid); end
    @(negedge clk);
    checks++; if (port_req !== 1'b1 || port_addr !== 32'h400) begin errors++; $display("FAIL ack_kill_refetch: req %b addr %h want 1 400", port_req, port_addr); end
    port_ack = 1'b1; port_rdata = 32'h0000_0ABC;
    @(negedge clk);
    port_ack = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_0ABC) begin errors++; $display("FAIL ack_kill_next: if_valid %b inst %h want 1 00000abc", if_valid, if_inst); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ack_in_idle();
    port_ack = 1'b1; port_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    port_ack = 1'b0;
    checks++; if (if_valid !== 1'b0 || mem_done !== 1'b0 || port_req !== 1'b0) begin errors++; $display("FAIL idle_ack: if_valid %b done %b req %b want 0 0 0", if_valid, mem_done, port_req); end
    checks++; if (mem_rdata === 32'hFFFF_FFFF || if_inst === 32'hFFFF_FFFF) begin errors++; $display("FAIL idle_ack_capture: rdata %h inst %h want neither ffffffff", mem_rdata, if_inst); end
  endtask

  task automatic test_id_hazard();
    id_stallreq = 1'b1;
    #1;
    checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL haz_id_only: got %b want 000111", stall); end
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500;
    #1;
    checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL haz_with_mem: got %b want 011111", stall); end
    @(negedge clk);
    port_ack = 1'b1; port_rdata = 32'h0000_5555;
    @(negedge clk);
    port_ack = 1'b0;
    checks++; if (mem_done !== 1'b1 || stall !== 6'b000111) begin errors++; $display("FAIL haz_mem_done: done %b stall %b want 1 000111", mem_done, stall); end
    mem_req = 1'b0; id_stallreq = 1'b0;
    #1;
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL haz_clear: got %b want 000000", stall); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h600; mem_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (port_req !== 1'b1 || port_addr !== 32'h600) begin errors++; $display("FAIL rstmid_busy: req %b addr %h want 1 600", port_req, port_addr); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (port_req !== 1'b0 || port_addr !== 32'h0 || port_we !== 1'b0 || port_wdata !== 32'h0) begin errors++; $display("FAIL rstmid_port: req %b addr %h we %b wdata %h want 0", port_req, port_addr, port_we, port_wdata); end
    checks++; if (mem_done !== 1'b0 || if_valid !== 1'b0 || mem_rdata !== 32'h0 || if_inst !== 32'h0) begin errors++; $display("FAIL rstmid_out: done %b if_valid %b rdata %h inst %h want 0", mem_done, if_valid, mem_rdata, if_inst); end
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    port_ack = 1'b1; port_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    port_ack = 1'b0;
    checks++; if (mem_done !== 1'b0 || mem_rdata !== 32'h0 || port_req !== 1'b0) begin errors++; $display("FAIL rstmid_late_ack: done %b rdata %h req %b want 0 0 0", mem_done, mem_rdata, port_req); end
  endtask

  task automatic test_random();
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        prev_ack = 1'b0;
    logic [5:0]  exp_stall;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (prev_req && !prev_ack) begin
        checks++; if (port_req !== 1'b1 || port_addr !== prev_addr) begin errors++; $display("FAIL rnd_port_hold c%0d: req %b addr %h want 1 %h", c, port_req, port_addr, prev_addr); end
      end
      prev_req = port_req; prev_addr = port_addr;
      if_req      = ($urandom_range(0, 3) != 0);
      if_addr     = $urandom_range(0, 255) << 2;
      mem_req     = ($urandom_range(0, 2) == 0);
      mem_we      = $urandom_range(0, 1);
      mem_addr    = $urandom_range(0, 255) << 2;
      mem_wdata   = $urandom;
      id_stallreq = ($urandom_range(0, 4) == 0);
      ex_b_flag   = ($urandom_range(0, 9) == 0);
      id_b_flag   = ($urandom_range(0, 9) == 0);
      port_ack    = ($urandom_range(0, 2) == 0);
      port_rdata  = $urandom;
      prev_ack    = port_ack;
      #1;
      exp_stall = 6'b000000;
      if (mem_req && !mem_done) exp_stall = exp_stall | 6'b011111;
      if (id_stallreq)          exp_stall = exp_stall | 6'b000111;
      if (if_req && !if_valid)  exp_stall = exp_stall | 6'b000011;
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall, exp_stall); end
      checks++; if (stall[5] !== 1'b0 || (stall[4] && !stall[3]) || (stall[3] && !stall[2]) || (stall[2] && !stall[1]) || (stall[1] && !stall[0])) begin errors++; $display("FAIL rnd_monotonic c%0d: got %b want monotonic", c, stall); end
      checks++; if (if_valid && mem_done) begin errors++; $display("FAIL rnd_excl c%0d: if_valid %b mem_done %b want not both", c, if_valid, mem_done); end
    end
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; id_stallreq = 1'b0;
    ex_b_flag = 1'b0; id_b_flag = 1'b0; port_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch_k3();
    test_simultaneous();
    test_store();
    test_branch_kill();
    test_kill_with_ack();
    test_ack_in_idle();
    test_id_hazard();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
